liic_ll_prio_mux: RTL

Link-layer transmit arbiter between a `liic_dn_link`/`liic_up_link` instance and a single-channel physical link layer. It merges the high-priority (`llhp_o_*`) and low-priority (`lllp_o_*`) outbound packet streams into one stream. Arbitration is packet-atomic, and a starvation guard bounds how long low priority can be held off. Each output word carries a channel tag so the far-end demux can restore the two streams.

---
 rtl/liic_ll_pkg.sv | 22 ++
 rtl/liic_ll_skid_buf.sv | 69 ++++++
 rtl/liic_ll_prio_mux.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/liic_ll_pkg.sv
// Shared link-layer types for the transmit priority mux and its matching
// receive demux.
//   ll_chn_t       : channel tag carried on every merged word (LP=0, HP=1)
//   ll_arb_state_t : transmit arbiter grant state
// The packed word {chn, sop, eop, dat} depends on ST_WIDTH, so it is declared
// inside each module that uses it. LL_TAG_W is the width of its non-data part.
package liic_ll_pkg;

  typedef enum logic {
    CHN_LP = 1'b0,
    CHN_HP = 1'b1
  } ll_chn_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HP   = 2'd1,
    ST_LP   = 2'd2
  } ll_arb_state_t;

  localparam int LL_TAG_W = 3;

endpackage

// File: rtl/liic_ll_skid_buf.sv
// Two-entry valid/ready register buffer with synchronous clear.
// The output word comes straight from a register. The upstream ready is
// derived only from the fill count, so it is registered too. Because it has two
// entries, full throughput is kept even though ready is registered.
// Ports:
//   clk            : clock
//   i_clr          : synchronous clear (empties buffer, zeroes storage)
//   i_dat/i_val    : upstream word / valid
//   o_rdy          : upstream ready (buffer not full)
//   o_dat/o_val    : downstream word / valid
//   i_rdy          : downstream ready
// Handshake: a word moves on any interface when val & rdy are both high at a
// rising edge. The source holds its word stable while val & !rdy.
module liic_ll_skid_buf #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic [W-1:0] i_dat,
  input  logic         i_val,
  output logic         o_rdy,
  output logic [W-1:0] o_dat,
  output logic         o_val,
  input  logic         i_rdy
);

  logic [W-1:0] r_mem0;  // head, drives the output
  logic [W-1:0] r_mem1;  // second entry
  logic [1:0]   r_cnt;
  logic         w_push;
  logic         w_pop;

  assign o_rdy  = (r_cnt != 2'd2);
  assign o_val  = (r_cnt != 2'd0);
  assign o_dat  = r_mem0;
  assign w_push = i_val & o_rdy;
  assign w_pop  = o_val & i_rdy;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_cnt  <= 2'd0;
      r_mem0 <= '0;
      r_mem1 <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_mem0 <= i_dat;
          else               r_mem1 <= i_dat;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_mem0 <= r_mem1;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          // A push is only possible below 2 entries, so the count stays unchanged.
          if (r_cnt == 2'd1) begin
            r_mem0 <= i_dat;
          end else begin
            r_mem0 <= r_mem1;
            r_mem1 <= i_dat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/liic_ll_prio_mux.sv
// Link-layer transmit arbiter. It merges the high-priority and low-priority
// packet streams into one tagged stream. Arbitration is per packet: once a
// packet is granted, its channel keeps the grant until its eop word transfers.
// HP normally wins. A starvation guard gives LP the next grant after LP_MAXWAIT
// consecutive HP grants made while LP was waiting.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   ll_linkup                        : link up; low acts exactly like rst
//   hp_i_dat/val/sop/eop, hp_i_rdy   : HP input stream
//   lp_i_dat/val/sop/eop, lp_i_rdy   : LP input stream
//   ll_o_dat/val/sop/eop/chn, ll_o_rdy : merged output (chn 1=HP, 0=LP)
//   o_dbg_state, o_dbg_wait_cnt      : arbiter state and starvation counter
// Handshake: a word moves on any interface when val & rdy are both high at a
// rising edge. The source holds dat/sop/eop stable while val & !rdy.
module liic_ll_prio_mux
  import liic_ll_pkg::*;
#(
  parameter  int ST_WIDTH   = 8,
  parameter  int LP_MAXWAIT = 4,
  localparam int WCNT_W     = $clog2(LP_MAXWAIT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ll_linkup,
  input  logic [ST_WIDTH-1:0] hp_i_dat,
  input  logic                hp_i_val,
  input  logic                hp_i_sop,
  input  logic                hp_i_eop,
  output logic                hp_i_rdy,
  input  logic [ST_WIDTH-1:0] lp_i_dat,
  input  logic                lp_i_val,
  input  logic                lp_i_sop,
  input  logic                lp_i_eop,
  output logic                lp_i_rdy,
  output logic [ST_WIDTH-1:0] ll_o_dat,
  output logic                ll_o_val,
  output logic                ll_o_sop,
  output logic                ll_o_eop,
  output logic                ll_o_chn,
  input  logic                ll_o_rdy,
  output ll_arb_state_t       o_dbg_state,
  output logic [WCNT_W-1:0]   o_dbg_wait_cnt
);

  typedef struct packed {
    ll_chn_t             chn;
    logic                sop;
    logic                eop;
    logic [ST_WIDTH-1:0] dat;
  } ll_word_t;

  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(LP_MAXWAIT);

  ll_arb_state_t     r_state;
  ll_arb_state_t     w_grant;
  ll_arb_state_t     w_state_nx;
  logic [WCNT_W-1:0] r_wait_cnt;
  logic [WCNT_W-1:0] w_wait_nx;
  logic              w_clr;
  logic              w_buf_rdy;
  logic              w_hp_xfer;
  logic              w_lp_xfer;
  logic              w_in_val;
  ll_word_t          w_in_word;
  ll_word_t          w_buf_word;

  // Link down clears everything exactly like reset. The far end drops the
  // abandoned partial packet when its own link-layer reset runs.
  assign w_clr = rst | ~ll_linkup;

  // The grant is decided from IDLE in the same cycle, so the first word of a
  // packet is forwarded without a bubble.
  always_comb begin
    w_grant = r_state;
    if (r_state == ST_IDLE) begin
      if (hp_i_val && (!lp_i_val || (r_wait_cnt < WCNT_MAX))) w_grant = ST_HP;
      else if (lp_i_val)                                    w_grant = ST_LP;
      else                                                  w_grant = ST_IDLE;
    end
  end

  assign hp_i_rdy  = ~w_clr & (w_grant == ST_HP) & w_buf_rdy;
  assign lp_i_rdy  = ~w_clr & (w_grant == ST_LP) & w_buf_rdy;
  assign w_hp_xfer = hp_i_val & hp_i_rdy;
  assign w_lp_xfer = lp_i_val & lp_i_rdy;
  assign w_in_val  = w_hp_xfer | w_lp_xfer;

  always_comb begin
    w_in_word = '0;
    if (w_grant == ST_LP) begin
      w_in_word.chn = CHN_LP;
      w_in_word.sop = lp_i_sop;
      w_in_word.eop = lp_i_eop;
      w_in_word.dat = lp_i_dat;
    end else begin
      w_in_word.chn = CHN_HP;
      w_in_word.sop = hp_i_sop;
      w_in_word.eop = hp_i_eop;
      w_in_word.dat = hp_i_dat;
    end
  end

  // Next state and counter. An IDLE grant locks the channel even if the buffer
  // stalls the first word, because the source must hold that word anyway.
  always_comb begin
    w_state_nx = w_grant;
    w_wait_nx  = r_wait_cnt;
    if ((w_hp_xfer && hp_i_eop) || (w_lp_xfer && lp_i_eop)) w_state_nx = ST_IDLE;
    if (r_state == ST_IDLE) begin
      if (!lp_i_val || (w_grant == ST_LP)) begin
        w_wait_nx = '0;
      end else if ((w_grant == ST_HP) && (r_wait_cnt != WCNT_MAX)) begin
        w_wait_nx = r_wait_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_wait_cnt <= w_wait_nx;
    end
  end

  liic_ll_skid_buf #(
    .W (ST_WIDTH + LL_TAG_W)
  ) u_obuf (
    .clk   (clk),
    .i_clr (w_clr),
    .i_dat (w_in_word),
    .i_val (w_in_val),
    .o_rdy (w_buf_rdy),
    .o_dat (w_buf_word),
    .o_val (ll_o_val),
    .i_rdy (ll_o_rdy)
  );

  assign ll_o_dat       = w_buf_word.dat;
  assign ll_o_sop       = w_buf_word.sop;
  assign ll_o_eop       = w_buf_word.eop;
  assign ll_o_chn       = w_buf_word.chn;
  assign o_dbg_state    = r_state;
  assign o_dbg_wait_cnt = r_wait_cnt;

endmodule
